// File: rtl/pixel_frame_buffer_if.sv
// pixel_frame_buffer_if
//   Bundle between the pixel source / CNN datapath and pixel_frame_buffer.
//   Handshake: pixel_i is taken on any rising edge where pixel_i_valid=1.
//   There is no ready signal and no backpressure. A pixel presented while the
//   buffer is not loading is lost and raises the sticky pixel_drop flag.
//   Reads work the same way: rd_en with rd_addr is sampled on an edge, and
//   rd_data/rd_data_valid follow one cycle later.
//   Signals:
//     pixel_i, pixel_i_valid      pixel stream in, row-major
//     rd_en, rd_addr              random-access read request
//     rd_data, rd_data_valid      registered read response
//     frame_ready                 a complete frame is held
//     frame_release               one-cycle pulse, the consumer is done
//     pixel_drop                  sticky, a pixel arrived while not loading
//     frame_count                 count of released frames, wraps
//     state_dbg                   current FSM state (0 = LOAD, 1 = FULL)
//   modport master: source/consumer side.  modport slave: the buffer.
interface pixel_frame_buffer_if #(
    parameter int GS_BITS   = 8,
    parameter int ADDR_BITS = 10
);
    logic [GS_BITS-1:0]   pixel_i;
    logic                 pixel_i_valid;
    logic                 rd_en;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [GS_BITS-1:0]   rd_data;
    logic                 rd_data_valid;
    logic                 frame_ready;
    logic                 frame_release;
    logic                 pixel_drop;
    logic [15:0]          frame_count;
    logic                 state_dbg;

    modport master (
        output pixel_i, pixel_i_valid, rd_en, rd_addr, frame_release,
        input  rd_data, rd_data_valid, frame_ready, pixel_drop, frame_count,
               state_dbg
    );

    modport slave (
        input  pixel_i, pixel_i_valid, rd_en, rd_addr, frame_release,
        output rd_data, rd_data_valid, frame_ready, pixel_drop, frame_count,
               state_dbg
    );
endinterface

// File: rtl/pixel_frame_buffer.sv
// pixel_frame_buffer
//   Captures one IMG_DIM x IMG_DIM greyscale frame from a row-major pixel
//   stream into a frame RAM. It then holds the frame (frame_ready=1) and
//   serves one-cycle-latency random reads until the consumer pulses
//   frame_release.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   pixel_frame_buffer_if.slave (see the interface header)
//   The FSM has two states. LOAD accepts pixels. FULL serves reads and drops
//   any incoming pixels.
module pixel_frame_buffer #(
    parameter int GS_BITS   = 8,
    parameter int IMG_DIM   = 30,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    pixel_frame_buffer_if.slave  bus
);

    localparam int FRAME_PIX = IMG_DIM * IMG_DIM;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FRAME_PIX - 1);
    localparam logic [ADDR_BITS-1:0] FRAME_END = ADDR_BITS'(FRAME_PIX);

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [GS_BITS-1:0]   rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 drop_q, drop_d;
    logic [15:0]          count_q, count_d;

    // Frame RAM. It has one write port and one read port, and reset does not
    // clear it.
    logic [GS_BITS-1:0]   mem_q [FRAME_PIX];

    logic wr_en;
    logic rd_hit;
    logic rd_in_range;

    assign wr_en       = (state_q == ST_LOAD) && bus.pixel_i_valid;
    assign rd_hit      = (state_q == ST_FULL) && bus.rd_en;
    assign rd_in_range = bus.rd_addr < FRAME_END;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.pixel_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_data_d  = rd_data_q;   // rd_data holds between reads
        rd_valid_d = 1'b0;
        drop_d     = drop_q;
        count_d    = count_q;

        case (state_q)
            ST_LOAD: begin
                if (bus.pixel_i_valid) begin
                    if (wr_ptr_q == LAST_ADDR) begin
                        wr_ptr_d = '0;
                        state_d  = ST_FULL;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            default: begin
                if (rd_hit) begin
                    rd_valid_d = 1'b1;
                    // Addresses past the frame read as zero rather than
                    // aliasing into the RAM.
                    rd_data_d  = rd_in_range ? mem_q[bus.rd_addr] : '0;
                end
                // A pixel in the release cycle still belongs to the old
                // frame, so it is dropped.
                if (bus.pixel_i_valid) begin
                    drop_d = 1'b1;
                end
                if (bus.frame_release) begin
                    state_d = ST_LOAD;
                    count_d = count_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            wr_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            drop_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
        end
    end

    assign bus.rd_data       = rd_data_q;
    assign bus.rd_data_valid = rd_valid_q;
    assign bus.frame_ready   = (state_q == ST_FULL);
    assign bus.pixel_drop    = drop_q;
    assign bus.frame_count   = count_q;
    assign bus.state_dbg     = state_q[0];

endmodule

// File: doc/pixel_frame_buffer.md
# pixel_frame_buffer

Receiving end of the pixel stream that feeds the CNN. It accepts one 30x30 greyscale image as a row-major `pixel_i`/`pixel_i_valid` stream and stores it in a frame RAM. It then raises `frame_ready` and serves random-access reads to the CNN datapath. It holds the frame until the CNN releases it, which the CNN does on the cycle it produces its digit. Incoming pixels are accepted only while a frame is being loaded; anything else is dropped and flagged.

## Interface
- `GS_BITS`, 8, pixel width.
- `IMG_DIM`, 30, image side length; one frame is `IMG_DIM*IMG_DIM` (900) pixels.
- `ADDR_BITS`, 10, width of the frame address; must satisfy 2^`ADDR_BITS` >= `IMG_DIM*IMG_DIM`.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pixel_i`  in  `GS_BITS`  incoming pixel, row-major order.
- `pixel_i_valid`  in  1  `pixel_i` is valid this cycle; there is no backpressure.
- `rd_en`  in  1  read request.
- `rd_addr`  in  `ADDR_BITS`  read address, row*`IMG_DIM`+col.
- `rd_data`  out  `GS_BITS`  registered read data.
- `rd_data_valid`  out  1  `rd_data` is valid.
- `frame_ready`  out  1  a complete frame is held.
- `frame_release`  in  1  single-cycle pulse: the consumer is done with the frame.
- `pixel_drop`  out  1  sticky: a pixel arrived while not loading.
- `frame_count`  out  16  number of frames released; wraps.

## Operation
- Two states, `LOAD` and `FULL`. Reset state is `LOAD`.
- Write counter `wr_ptr` (`ADDR_BITS` wide) runs 0..899.

`LOAD` state:
- `pixel_i_valid`=1 writes `pixel_i` to RAM[`wr_ptr`] and increments `wr_ptr`.
- When the accepted pixel has `wr_ptr`=899, `wr_ptr` returns to 0 and the state goes to `FULL`.
- `frame_release` is ignored.
- `rd_en` is ignored: `rd_data_valid` stays 0 and `rd_data` holds its value.

`FULL` state:
- `frame_ready`=1.
- `rd_en`=1 returns RAM[`rd_addr`] on `rd_data` with `rd_data_valid`=1.
- If `rd_addr` >= 900 the read returns `rd_data`=0, still with `rd_data_valid`=1.
- `frame_release`=1 moves the state to `LOAD` and increments `frame_count` (modulo 2^16).
- `pixel_i_valid`=1 while the state is `FULL` discards the pixel and sets `pixel_drop`. This includes the cycle in which `frame_release` is asserted.

Other rules:
- `pixel_drop` clears only on reset.
- RAM is inferred as simple dual-port (one write port, one read port). Its contents are not cleared by reset.
- Reset mid-frame discards the partial frame: `wr_ptr`=0, state `LOAD`.

## Timing
Reset values: `rd_data`=0, `rd_data_valid`=0, `frame_ready`=0, `pixel_drop`=0, `frame_count`=0.

Latencies:
- Read latency is 1 cycle. `rd_en` sampled at edge N gives `rd_data`/`rd_data_valid` after edge N.
- `rd_data_valid` is 1 only in the cycle following an accepted read.
- `frame_ready` rises the cycle after the 900th pixel is accepted.
- `frame_ready` falls the cycle after `frame_release` is sampled.
- `frame_count` updates the same cycle `frame_ready` falls.

Boundary rules:
- A pixel presented the cycle after `frame_release` is sampled is accepted as pixel 0 of the next frame.
- A read and `frame_release` in the same cycle: the read completes normally, and its data appears the cycle after.
- Back-to-back pixels, one per clock, must be accepted without loss during `LOAD`.
- Reset asserted while `rd_data_valid`=1 forces `rd_data_valid` to 0 immediately, since reset is asynchronous.

## Test plan
1. Reset, then stream 900 pixels with value (i mod 256), one per clock -> `frame_ready`=1 one cycle after the last pixel. Read addresses 0, 29, 30, 899 -> `rd_data` = 0x00, 0x1D, 0x1E, 0x83, each one cycle after its request, with `rd_data_valid`=1.
2. Frame loaded, `rd_addr`=900 and `rd_addr`=1023 with `rd_en`=1 -> `rd_data`=0, `rd_data_valid`=1. Asserting `rd_en` during `LOAD` -> `rd_data_valid` stays 0.
3. Frame loaded, drive one extra pixel -> `pixel_drop`=1, still 1 after the frame is released, and RAM[0] unchanged.
4. Pulse `frame_release`, then stream a second frame of all 0xAA starting the next cycle -> `frame_count`=1, `frame_ready` goes 0 then 1, and a read of address 450 returns 0xAA.
5. Assert `rst` after 500 pixels of a frame, then stream 900 pixels -> `frame_ready` rises only after all 900 new pixels, and address 0 holds the first post-reset pixel.
6. Run 3 frames with `frame_release` asserted in the same cycle as a pixel -> that pixel is dropped (`pixel_drop`=1), the next frame loads correctly, and `frame_count`=3.
